// File: rtl/regfile_bus_sequencer.sv
// rtl/regfile_bus_sequencer.sv - register-file command bus initiator for one micro-op at a time
module regfile_bus_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [INDEX_WIDTH-1:0]   req_sel_a,
    input  logic [INDEX_WIDTH-1:0]   req_sel_b,
    input  logic [INDEX_WIDTH-1:0]   req_sel_c,
    input  logic [1:0]               req_wsel,
    input  logic                     req_read_f,
    output logic [3:0]               bus_cmd,
    output logic [3*INDEX_WIDTH-1:0] bus_sel,
    input  logic [DATA_WIDTH-1:0]    bus_rdata,
    output logic [DATA_WIDTH-1:0]    bus_wdata,
    output logic                     op_valid,
    output logic [DATA_WIDTH-1:0]    op_a,
    output logic [DATA_WIDTH-1:0]    op_b,
    output logic [DATA_WIDTH-1:0]    op_f,
    input  logic                     alu_done,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic                     done,
    output logic                     err
);

    localparam logic [3:0] COM_NOP      = 4'd0;
    localparam logic [3:0] COM_READA    = 4'd1;
    localparam logic [3:0] COM_READB    = 4'd2;
    localparam logic [3:0] COM_LATCHC   = 4'd3;
    localparam logic [3:0] COM_LATCHSEL = 4'd4;
    localparam logic [3:0] COM_READF    = 4'd5;
    localparam logic [3:0] COM_SLAVE    = 4'd6;

    localparam logic [1:0] WSEL_NONE = 2'd0;
    localparam logic [1:0] WSEL_REGC = 2'd1;
    localparam logic [1:0] WSEL_REGF = 2'd2;
    localparam logic [1:0] WSEL_RFU  = 2'd3;

    localparam logic [INDEX_WIDTH-1:0] R_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_RDA,
        S_RDB,
        S_RDF,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [3*INDEX_WIDTH-1:0]   sel_q;
    logic [1:0]                 wsel_q;
    logic                       read_f_q;
    logic [DATA_WIDTH-1:0]      op_a_q;
    logic [DATA_WIDTH-1:0]      op_b_q;
    logic [DATA_WIDTH-1:0]      op_f_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic                       accept;
    logic                       write_c;

    assign accept  = (state_q == S_IDLE) && req_valid;
    // Writes to the zero register are suppressed on the bus, not left to the register file.
    assign write_c = (wsel_q == WSEL_REGC) && (sel_q[INDEX_WIDTH-1:0] != R_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_SEL;
            S_SEL:   state_d = S_RDA;
            S_RDA:   state_d = S_RDB;
            S_RDB:   state_d = read_f_q ? S_RDF : S_EXEC;
            S_RDF:   state_d = S_EXEC;
            S_EXEC:  if (alu_done) state_d = S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_cmd   = COM_NOP;
        req_ready = 1'b0;
        op_valid  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_SEL:  bus_cmd   = COM_LATCHSEL;
            S_RDA:  bus_cmd   = COM_READA;
            S_RDB:  bus_cmd   = COM_READB;
            S_RDF:  bus_cmd   = COM_READF;
            S_EXEC: op_valid  = 1'b1;
            S_WB: begin
                if (write_c) begin
                    bus_cmd = COM_LATCHC;
                end else if (wsel_q == WSEL_REGF) begin
                    bus_cmd = COM_SLAVE;
                end else begin
                    bus_cmd = COM_NOP;
                end
            end
            S_DONE: begin
                done = 1'b1;
                err  = (wsel_q == WSEL_RFU);
            end
            default: bus_cmd = COM_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            wsel_q   <= WSEL_NONE;
            read_f_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_f_q   <= '0;
            wdata_q  <= '0;
        end else begin
            if (accept) begin
                sel_q    <= {req_sel_a, req_sel_b, req_sel_c};
                wsel_q   <= req_wsel;
                read_f_q <= req_read_f;
            end
            if (state_q == S_RDA) op_a_q <= bus_rdata;
            if (state_q == S_RDB) op_b_q <= bus_rdata;
            if (state_q == S_RDF) op_f_q <= bus_rdata;
            if ((state_q == S_EXEC) && alu_done) wdata_q <= alu_result;
        end
    end

    assign bus_sel   = sel_q;
    assign bus_wdata = wdata_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_f      = op_f_q;

endmodule

// File: tb/tb_regfile_bus_sequencer.sv
// tb/tb_regfile_bus_sequencer.sv - directed and randomized bench for regfile_bus_sequencer
module tb_regfile_bus_sequencer;

    localparam int DW = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] req_sel_a, req_sel_b, req_sel_c;
    logic [1:0]    req_wsel;
    logic          req_read_f;
    logic [3:0]    bus_cmd;
    logic [3*IW-1:0] bus_sel;
    logic [DW-1:0] bus_rdata;
    logic [DW-1:0] bus_wdata;
    logic          op_valid;
    logic [DW-1:0] op_a, op_b, op_f;
    logic          alu_done;
    logic [DW-1:0] alu_result;
    logic          done, err;

    logic [DW-1:0] ra, rb, rf, res;
    logic [DW-1:0] m_op_f;
    int tests = 0;
    int fails = 0;

    regfile_bus_sequencer #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel_a(req_sel_a), .req_sel_b(req_sel_b), .req_sel_c(req_sel_c),
        .req_wsel(req_wsel), .req_read_f(req_read_f),
        .bus_cmd(bus_cmd), .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_wdata(bus_wdata),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_f(op_f),
        .alu_done(alu_done), .alu_result(alu_result),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Register file model: returns per-transaction operand values on read commands only.
    always_comb begin
        case (bus_cmd)
            4'd1:    bus_rdata = ra;
            4'd2:    bus_rdata = rb;
            4'd5:    bus_rdata = rf;
            default: bus_rdata = 16'hDEAD;
        endcase
    end
    assign alu_result = res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [IW-1:0] c,
                           input logic [1:0] wsel, input logic f, input int stall, input bit hold_valid,
                           input logic [DW-1:0] va, input logic [DW-1:0] vb,
                           input logic [DW-1:0] vf, input logic [DW-1:0] vr);
        logic [63:0] exp_seq, got_seq;
        logic [3:0]  wb_cmd;
        logic [3*IW-1:0] got_sel;
        logic [DW-1:0] got_w;
        int n, done_i, ov, ex, rdy_cnt, wcnt, scnt, exp_len;
        logic got_err;
        ra = va; rb = vb; rf = vf; res = vr;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_sel_a = a; req_sel_b = b; req_sel_c = c;
        req_wsel = wsel; req_read_f = f; alu_done = 1'($urandom);

        wb_cmd = (wsel == 2'd1) ? ((c != '0) ? 4'd3 : 4'd0) : ((wsel == 2'd2) ? 4'd6 : 4'd0);
        exp_seq = 64'h41_2;
        exp_len = 3;
        if (f) begin exp_seq = {exp_seq[59:0], 4'd5}; exp_len++; end
        for (int k = 0; k <= stall; k++) begin exp_seq = {exp_seq[59:0], 4'd0}; exp_len++; end
        exp_seq = {exp_seq[55:0], wb_cmd, 4'd0};
        exp_len += 2;

        got_seq = '0; got_sel = '0; got_w = '0; got_err = 1'b0;
        done_i = 0; ov = 0; ex = 0; rdy_cnt = 0; wcnt = 0; scnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1 && !hold_valid) begin
                req_valid = 1'b0; req_sel_a = IW'($urandom); req_sel_b = IW'($urandom);
                req_sel_c = IW'($urandom); req_wsel = 2'($urandom); req_read_f = 1'($urandom);
            end
            got_seq = {got_seq[59:0], bus_cmd};
            if (req_ready) rdy_cnt++;
            if (op_valid) begin
                ov++;
                alu_done = (ex == stall);
                ex++;
            end else begin
                alu_done = 1'($urandom);
            end
            if (bus_cmd == 4'd4) got_sel = bus_sel;
            if (bus_cmd == 4'd3) begin got_w = bus_wdata; wcnt++; end
            if (bus_cmd == 4'd6) scnt++;
            if (done) begin
                done_i = i;
                got_err = err;
                break;
            end
        end
        req_valid = 1'b0;
        if (f) m_op_f = vf;

        check("done_cycle", 64'(done_i), 64'(exp_len));
        check("cmd_seq", got_seq, exp_seq);
        check("op_a", 64'(op_a), 64'(va));
        check("op_b", 64'(op_b), 64'(vb));
        check("op_f", 64'(op_f), 64'(m_op_f));
        check("bus_sel", 64'(got_sel), 64'({a, b, c}));
        check("err", {63'd0, got_err}, {63'd0, (wsel == 2'd3)});
        check("op_valid_cycles", 64'(ov), 64'(stall + 1));
        check("ready_in_flight", 64'(rdy_cnt), 64'd0);
        check("latchc_count", 64'(wcnt), 64'(wb_cmd == 4'd3));
        check("slave_count", 64'(scnt), 64'(wb_cmd == 4'd6));
        if (wb_cmd == 4'd3) check("wdata", 64'(got_w), 64'(vr));
        @(negedge clk);
        check("ready_after", {63'd0, req_ready}, 64'd1);
        check("done_pulse_width", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_sel_a = '0; req_sel_b = '0; req_sel_c = '0;
        req_wsel = '0; req_read_f = 1'b0; alu_done = 1'b0;
        ra = '0; rb = '0; rf = '0; res = '0; m_op_f = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd", 64'(bus_cmd), 64'd0);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_flags", {61'd0, op_valid, done, err}, 64'd0);
        check("rst_ops", {op_a, op_b, op_f}, 64'd0);
        check("rst_sel_wdata", {bus_sel, bus_wdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(3'd1, 3'd2, 3'd3, 2'd1, 1'b0, 0, 1'b0, 16'h0011, 16'h0022, 16'h0099, 16'h0033);
        run_txn(3'd4, 3'd5, 3'd6, 2'd2, 1'b1, 0, 1'b0, 16'h1234, 16'h5678, 16'h0005, 16'h0777);
        run_txn(3'd1, 3'd2, 3'd0, 2'd1, 1'b0, 1, 1'b0, 16'h00A1, 16'h00B2, 16'h0000, 16'hBEEF);
        run_txn(3'd7, 3'd0, 3'd2, 2'd3, 1'b0, 0, 1'b0, 16'h0101, 16'h0202, 16'h0000, 16'h0303);
        run_txn(3'd2, 3'd3, 3'd4, 2'd1, 1'b0, 3, 1'b1, 16'h4444, 16'h5555, 16'h0000, 16'h6666);

        // Reset during RDB: the bus must fall back to NOP at once and never write.
        ra = 16'h0AAA; rb = 16'h0BBB; res = 16'h0CCC;
        req_valid = 1'b1; req_sel_a = 3'd1; req_sel_b = 3'd2; req_sel_c = 3'd5;
        req_wsel = 2'd1; req_read_f = 1'b1; alu_done = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (bus_cmd != 4'd2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reached_rdb", 64'(bus_cmd), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd", 64'(bus_cmd), 64'd0);
        check("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        check("mid_rst_op_a", 64'(op_a), 64'd0);
        n = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus_cmd == 4'd3 || bus_cmd == 4'd6) n++;
        end
        check("mid_rst_no_write", 64'(n), 64'd0);
        rst_n = 1'b1;
        m_op_f = '0;
        @(negedge clk);
        run_txn(3'd6, 3'd1, 3'd2, 2'd1, 1'b0, 0, 1'b0, 16'h1111, 16'h2222, 16'h0000, 16'h3333);

        for (int t = 0; t < 20; t++) begin
            run_txn(IW'($urandom), IW'($urandom), IW'($urandom), 2'($urandom), 1'($urandom),
                    int'($urandom_range(0, 4)), 1'($urandom),
                    DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
